// File: rtl/cpu_pkg.sv
// cpu_pkg: decode constants and PC-stage state type shared by the PC
// stage and the control unit.
//   OP_*        : instruction[31:26] opcode values
//   FN_*        : instruction[5:0] funct values (R-type only)
//   pc_state_t  : run / halt / fault state of the PC stage
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next.sv
// pc_next: purely combinational next-PC selection and stop detection.
// Ports:
//   pc               in  32  current PC
//   opcode, funct    in  6   decoded instruction fields
//   immi             in  16  branch offset (words, signed)
//   jtarget          in  26  jump target (words)
//   alu_zero         in  1   ALU zero flag
//   rs_data          in  32  jr target
//   next_pc          out 32  PC for the next instruction
//   is_halt          out 1   halt or syscall is current
//   is_jr_misaligned out 1   jr to a non-word-aligned address
module pc_next
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [15:0] immi,
    input  logic [25:0] jtarget,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        is_halt,
    output logic        is_jr_misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic        is_jr;

    assign seq_pc    = pc + 32'd4;
    // Sign-extended word offset, shifted to a byte offset.
    assign branch_pc = seq_pc + {{14{immi[15]}}, immi, 2'b00};
    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign jump_pc   = {seq_pc[31:28], jtarget, 2'b00};

    assign is_jr            = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_jr_misaligned = is_jr && (rs_data[1:0] != 2'b00);
    assign is_halt          = (opcode == OP_HALT) ||
                              ((opcode == OP_RTYPE) && (funct == FN_SYSCALL));

    always_comb begin
        next_pc = seq_pc;
        if (opcode == OP_BEQ) begin
            next_pc = alu_zero ? branch_pc : seq_pc;
        end else if (opcode == OP_BNE) begin
            next_pc = alu_zero ? seq_pc : branch_pc;
        end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            next_pc = jump_pc;
        end else if (is_jr) begin
            next_pc = rs_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage. Holds the PC, the run/halt/fault state
// and the retired-instruction counter.
// Ports:
//   clk, rst     in   clock, asynchronous active-high reset
//   stall        in   freeze PC, counter and state this cycle
//   opcode..rs_data in decoded fields of the current instruction
//   PC           out  32     current PC to fetch
//   pc_plus4     out  32     PC + 4 (jal link value)
//   halted       out  1      state is HALT
//   fault        out  1      state is FAULT
//   retired      out  CNT_W  retired-instruction count (wraps)
//
// Flow control: stall is the only handshake. While stall = 1 nothing
// updates and halt/fault detection is suppressed; the current instruction
// is re-presented and consumed on the first edge with stall = 0.
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [15:0]      immi,
    input  logic [25:0]      jtarget,
    input  logic             alu_zero,
    input  logic [31:0]      rs_data,
    output logic [31:0]      PC,
    output logic [31:0]      pc_plus4,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    pc_state_t   state;
    logic [31:0] next_pc;
    logic        is_halt;
    logic        is_jr_misaligned;

    pc_next u_pc_next (
        .pc               (PC),
        .opcode           (opcode),
        .funct            (funct),
        .immi             (immi),
        .jtarget          (jtarget),
        .alu_zero         (alu_zero),
        .rs_data          (rs_data),
        .next_pc          (next_pc),
        .is_halt          (is_halt),
        .is_jr_misaligned (is_jr_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC      <= RESET_PC;
            retired <= '0;
            state   <= RUN;
        end else if ((state == RUN) && !stall) begin
            if (is_jr_misaligned) begin
                // The faulting jr does not retire; PC stays on it.
                state <= FAULT;
            end else if (is_halt) begin
                // The halt instruction retires but the PC stays on it.
                state   <= HALT;
                retired <= retired + CNT_W'(1);
            end else begin
                PC      <= next_pc;
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign pc_plus4 = PC + 32'd4;
    assign halted   = (state == HALT);
    assign fault    = (state == FAULT);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] immi;
    logic [25:0] jtarget;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic [31:0] PC;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .opcode   (opcode),
        .funct    (funct),
        .immi     (immi),
        .jtarget  (jtarget),
        .alu_zero (alu_zero),
        .rs_data  (rs_data),
        .PC       (PC),
        .pc_plus4 (pc_plus4),
        .halted   (halted),
        .fault    (fault),
        .retired  (retired)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector record ----------------
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] jt;
        logic        az;
        logic [31:0] rs;
        logic        st;
        logic [31:0] pp4;   // pc_plus4 before the edge
        logic [31:0] pc;    // PC after the edge
        logic [31:0] ret;   // retired after the edge
        logic        h;
        logic        f;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [25:0] jt,
                                input logic az, input logic [31:0] rs,
                                input logic st, input logic [31:0] pp4,
                                input logic [31:0] pc, input logic [31:0] ret,
                                input logic h, input logic f);
        vec_t v;
        v.op = op; v.fn = fn; v.imm = imm; v.jt = jt; v.az = az; v.rs = rs;
        v.st = st; v.pp4 = pp4; v.pc = pc; v.ret = ret; v.h = h; v.f = f;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [25:0] jt,
                         input logic az, input logic [31:0] rs, input logic st);
        opcode = op; funct = fn; immi = imm; jtarget = jt;
        alu_zero = az; rs_data = rs; stall = st;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc,
                               input logic [31:0] ret, input logic h, input logic f);
        chk({tag, "_pc"}, PC, pc);
        chk({tag, "_retired"}, retired, ret);
        chk({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
        chk({tag, "_fault"}, {31'd0, fault}, {31'd0, f});
    endtask

    // ---------------- test ----------------
    initial begin
        rst = 1'b1;
        drive(6'h00, 6'h20, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);

        tbl[0]  = mk(6'h00, 6'h20, 16'h0000, 26'h0,  1'b0, 32'h0,         1'b0, 32'h4,         32'h4,         32'd1,  1'b0, 1'b0);
        tbl[1]  = mk(6'h00, 6'h20, 16'h0000, 26'h0,  1'b0, 32'h0,         1'b0, 32'h8,         32'h8,         32'd2,  1'b0, 1'b0);
        tbl[2]  = mk(6'h00, 6'h20, 16'h0000, 26'h0,  1'b0, 32'h0,         1'b0, 32'hC,         32'hC,         32'd3,  1'b0, 1'b0);
        tbl[3]  = mk(6'h04, 6'h00, 16'hFFFE, 26'h0,  1'b1, 32'h0,         1'b0, 32'h10,        32'h8,         32'd4,  1'b0, 1'b0);
        tbl[4]  = mk(6'h04, 6'h00, 16'hFFFF, 26'h0,  1'b1, 32'h0,         1'b0, 32'hC,         32'h8,         32'd5,  1'b0, 1'b0);
        tbl[5]  = mk(6'h04, 6'h00, 16'hFFFF, 26'h0,  1'b0, 32'h0,         1'b0, 32'hC,         32'hC,         32'd6,  1'b0, 1'b0);
        tbl[6]  = mk(6'h04, 6'h00, 16'hFFFE, 26'h0,  1'b1, 32'h0,         1'b0, 32'h10,        32'h8,         32'd7,  1'b0, 1'b0);
        tbl[7]  = mk(6'h05, 6'h00, 16'h0002, 26'h0,  1'b0, 32'h0,         1'b0, 32'hC,         32'h14,        32'd8,  1'b0, 1'b0);
        tbl[8]  = mk(6'h05, 6'h00, 16'h0002, 26'h0,  1'b1, 32'h0,         1'b0, 32'h18,        32'h18,        32'd9,  1'b0, 1'b0);
        tbl[9]  = mk(6'h02, 6'h00, 16'h0000, 26'h40, 1'b0, 32'h0,         1'b0, 32'h1C,        32'h100,       32'd10, 1'b0, 1'b0);
        tbl[10] = mk(6'h02, 6'h00, 16'h0000, 26'h80, 1'b0, 32'h0,         1'b1, 32'h104,       32'h100,       32'd10, 1'b0, 1'b0);
        tbl[11] = mk(6'h00, 6'h08, 16'h0000, 26'h0,  1'b0, 32'hF000_0000, 1'b0, 32'h104,       32'hF000_0000, 32'd11, 1'b0, 1'b0);
        tbl[12] = mk(6'h03, 6'h00, 16'h0000, 26'h1,  1'b0, 32'h0,         1'b0, 32'hF000_0004, 32'hF000_0004, 32'd12, 1'b0, 1'b0);
        tbl[13] = mk(6'h00, 6'h08, 16'h0000, 26'h0,  1'b0, 32'h202,       1'b1, 32'hF000_0008, 32'hF000_0004, 32'd12, 1'b0, 1'b0);
        tbl[14] = mk(6'h00, 6'h08, 16'h0000, 26'h0,  1'b0, 32'h200,       1'b0, 32'hF000_0008, 32'h200,       32'd13, 1'b0, 1'b0);
        tbl[15] = mk(6'h3E, 6'h00, 16'h0000, 26'h0,  1'b0, 32'h0,         1'b0, 32'h204,       32'h204,       32'd14, 1'b0, 1'b0);
        tbl[16] = mk(6'h00, 6'h08, 16'h0000, 26'h0,  1'b0, 32'h202,       1'b0, 32'h208,       32'h204,       32'd14, 1'b0, 1'b1);
        tbl[17] = mk(6'h00, 6'h20, 16'h0000, 26'h0,  1'b0, 32'h0,         1'b0, 32'h208,       32'h204,       32'd14, 1'b0, 1'b1);
        tbl[18] = mk(6'h3F, 6'h00, 16'h0000, 26'h0,  1'b0, 32'h0,         1'b0, 32'h208,       32'h204,       32'd14, 1'b0, 1'b1);

        // Reset state
        do_reset();
        check_state("reset", 32'h0, 32'd0, 1'b0, 1'b0);
        chk("reset_pc_plus4", pc_plus4, 32'h4);

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].op, tbl[i].fn, tbl[i].imm, tbl[i].jt, tbl[i].az, tbl[i].rs, tbl[i].st);
            exp_q.push_back(tbl[i].pc);
            #1;
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, tbl[i].pp4);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), PC, exp_q.pop_front());
            chk($sformatf("v%0d_retired", i), retired, tbl[i].ret);
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].h});
            chk($sformatf("v%0d_fault", i), {31'd0, fault}, {31'd0, tbl[i].f});
            @(negedge clk);
        end

        // Reset clears FAULT
        do_reset();
        check_state("fault_rst", 32'h0, 32'd0, 1'b0, 1'b0);

        // Syscall at PC 0: retires, PC holds, halted next cycle
        drive(6'h00, 6'h0C, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check_state("syscall", 32'h0, 32'd1, 1'b1, 1'b0);

        // Halt at PC 0x20 with 2 stalled cycles first
        do_reset();
        drive(6'h00, 6'h08, 16'h0, 26'h0, 1'b0, 32'h20, 1'b0);
        @(posedge clk); #1;
        check_state("to_0x20", 32'h20, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(6'h3F, 6'h00, 16'h0, 26'h0, 1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check_state($sformatf("halt_stall%0d", c), 32'h20, 32'd1, 1'b0, 1'b0);
            @(negedge clk);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        check_state("halt_go", 32'h20, 32'd2, 1'b1, 1'b0);
        @(negedge clk);
        drive(6'h00, 6'h20, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check_state("halt_frozen", 32'h20, 32'd2, 1'b1, 1'b0);

        // Asynchronous reset while halted, mid-cycle
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 32'h0, 32'd0, 1'b0, 1'b0);
        chk("async_rst_pc_plus4", pc_plus4, 32'h4);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_state("after_rst_nop", 32'h4, 32'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
